mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline, placed between the EX/MEM and MEM/WB pipeline registers.
- Decodes the instruction in MEM and selects forwarded store data.
- Performs word/half/byte data-memory access with sign/zero extension.
- Produces write-back data, register addresses and RegWrite for the hazard unit and the WB stage.

Parameters:
- DM_WORDS, 1024: data memory depth in 32-bit words (power of two).
- DM_AW, 10: word-index width, equal to log2(DM_WORDS).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- Instr  in  32  instruction currently in MEM.
- PC  in  32  PC of that instruction, used for the write log.
- MemAddr  in  32  byte address (ALU result).
- GRFRData2  in  32  rt value carried from EX.
- W_GRFWData  in  32  WB-stage write-back data (forwarding source).
- EResult  in  32  EX result (ALU result, or PC+8 for jal).
- Trans_MemRD_Sel  in  2  store-data mux select.
- GRFWData  out  32  write-back data.
- ReadA1  out  5  rs read address.
- ReadA2  out  5  rt read address.
- WriteA  out  5  destination register.
- RegWrite  out  1  register write enable.

Behaviour:
- Decode is purely combinational from Instr. Any unknown opcode/funct, and Instr = 0, is a nop: all enables 0 and all addresses 0.
- Supported instructions:
  - R-type: addu (funct 21h), subu (23h), jr (08h).
  - I-type and jumps: ori 0Dh, lui 0Fh, beq 04h, j 02h, jal 03h.
  - Loads: lw 23h, lh 21h, lhu 25h, lb 20h, lbu 24h.
  - Stores: sw 2Bh, sh 29h, sb 28h.
- ReadA1 = Instr[25:21] for addu, subu, jr, ori, beq, all loads and all stores; 0 otherwise.
- ReadA2 = Instr[20:16] for addu, subu, beq and all stores; 0 otherwise.
- WriteA / RegWrite:
  - addu, subu: rd (Instr[15:11]), RegWrite = 1.
  - ori, lui, all loads: rt, RegWrite = 1.
  - jal: 31, RegWrite = 1.
  - All other instructions: WriteA = 0, RegWrite = 0.
- MemWrite = 1 only for stores.
- MemType encoding: 00 word, 01 half, 10 byte.
- MemSign = 1 for lh and lb only.
- MemtoReg: 1 for loads, 0 otherwise.
- Store data mux (Trans_MemRD_Sel): 00 GRFRData2, 01 W_GRFWData, 10/11 zero.
- Write-back mux: MemtoReg 0 gives EResult, 1 gives the extended load data.
- Data memory addressing:
  - Word index = MemAddr[DM_AW+1:2]. Higher bits are ignored, so out-of-range addresses wrap.
  - Little-endian byte lanes.
  - Word accesses ignore MemAddr[1:0]. Half accesses use MemAddr[1] and ignore bit 0. Byte accesses use MemAddr[1:0].
- Read is combinational:
  - word: full word.
  - half: selected 16 bits, sign- or zero-extended per MemSign.
  - byte: selected 8 bits, sign- or zero-extended per MemSign.
- Write happens on posedge clk when MemWrite = 1 and reset = 1.
  - Only the addressed lane(s) are merged; other bytes are preserved.
  - Same-cycle read of the written address returns the old value; the new value is visible after the edge.
- On every write, print exactly `@%h: *%h <= %h` with PC, the word-aligned byte address ({MemAddr[31:2],2'b00}) and the full merged word.
- reset = 0 asynchronously clears every memory word to 0 and suppresses writes. The decode outputs and muxes stay combinational; the stage has no other state.
- Latency: GRFWData for a load is valid in the same cycle the instruction is in MEM.

Decomposition:
- Shared package mips_pkg:
  - opcode and funct constants.
  - MemType encodings (MT_WORD, MT_HALF, MT_BYTE).
  - WB select constants (WB_ALU, WB_MEM).
  - store-forward select constants (FW_RT, FW_WB).
- One sub-module, mem_stage_dm: the storage array with lane merge, read extension, reset clear and the write log.
- Decode and muxes stay inline in mem_stage.

Test Plan:
- Reset with reset = 0, then release:
  - lw at MemAddr 0x10 → GRFWData = 0; RegWrite = 1; WriteA = rt.
- sw at 0x20 with GRFWData2 = 0x12345678, Sel = 00:
  - log `@<PC>: *00000020 <= 12345678`.
  - a following lw at 0x20 returns 0x12345678.
- sb of 0xAB (low byte of W_GRFWData, Sel = 01) at 0x21 over 0x12345678:
  - word becomes 0x1234AB78.
  - lb at 0x21 → 0xFFFFFFAB; lbu → 0x000000AB.
- sh of 0x8001 at 0x22, then lh at 0x22 → 0xFFFF8001 and lhu → 0x00008001.
  - The low half of the word is unchanged.
- Decode checks:
  - addu $3,$1,$2 → ReadA1 = 1, ReadA2 = 2, WriteA = 3, RegWrite = 1, GRFWData = EResult.
  - jal → WriteA = 31.
  - beq → RegWrite = 0, WriteA = 0.
  - Instr = 0 → all zero.
- Async reset asserted mid-cycle after stores → all words read 0 immediately; a store with reset low does not write.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, R-type functs, memory access types and
// the select values used by the MEM-stage muxes.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    typedef logic [1:0] mem_type_t;
    localparam mem_type_t MT_WORD = 2'b00;
    localparam mem_type_t MT_HALF = 2'b01;
    localparam mem_type_t MT_BYTE = 2'b10;

    localparam logic WB_ALU = 1'b0;
    localparam logic WB_MEM = 1'b1;

    localparam logic [1:0] FW_RT = 2'b00;
    localparam logic [1:0] FW_WB = 2'b01;

endpackage

// File: rtl/mem_stage_dm.sv
// Data memory for the MEM stage: little-endian word array with lane-merged
// stores, sign/zero-extended combinational reads and an async clear.
module mem_stage_dm
    import mips_pkg::*;
#(
    parameter int DM_WORDS = 1024,
    parameter int DM_AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  mem_type_t   mtype,
    input  logic        msign,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    logic [31:0]      mem [DM_WORDS];
    logic [DM_AW-1:0] idx;
    logic [31:0]      cur;
    logic [31:0]      half_sh;
    logic [31:0]      byte_sh;
    logic [31:0]      merged;

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
        logic signed [15:0] hs;
        hs = h;
        return sgn ? 32'(hs) : {16'b0, h};
    endfunction

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
        logic signed [7:0] bs;
        bs = b;
        return sgn ? 32'(bs) : {24'b0, b};
    endfunction

    // Upper address bits are dropped so out-of-range addresses wrap.
    assign idx     = addr[DM_AW+1:2];
    assign cur     = mem[idx];
    assign half_sh = cur >> {addr[1], 4'b0000};
    assign byte_sh = cur >> {addr[1:0], 3'b000};

    always_comb begin
        case (mtype)
            MT_HALF: rdata = ext_half(half_sh[15:0], msign);
            MT_BYTE: rdata = ext_byte(byte_sh[7:0], msign);
            default: rdata = cur;
        endcase
    end

    always_comb begin
        merged = cur;
        case (mtype)
            MT_HALF: begin
                if (addr[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            MT_BYTE: begin
                case (addr[1:0])
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            default: merged = wdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[idx] <= merged;
            $write("@%h: *%h <= %h\n", pc, {addr[31:2], 2'b00}, merged);
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: decodes the instruction in MEM, forwards store data,
// accesses data memory and selects the write-back value.
module mem_stage
    import mips_pkg::*;
#(
    parameter int DM_WORDS = 1024,
    parameter int DM_AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [31:0] PC,
    input  logic [31:0] MemAddr,
    input  logic [31:0] GRFRData2,
    input  logic [31:0] W_GRFWData,
    input  logic [31:0] EResult,
    input  logic [1:0]  Trans_MemRD_Sel,
    output logic [31:0] GRFWData,
    output logic [4:0]  ReadA1,
    output logic [4:0]  ReadA2,
    output logic [4:0]  WriteA,
    output logic        RegWrite
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        memwrite;
    mem_type_t   memtype;
    logic        memsign;
    logic        memtoreg;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        unused_shamt;

    assign op           = Instr[31:26];
    assign rs           = Instr[25:21];
    assign rt           = Instr[20:16];
    assign rd           = Instr[15:11];
    assign funct        = Instr[5:0];
    assign unused_shamt = ^Instr[10:6];

    // Unknown encodings fall through to the all-zero nop defaults.
    always_comb begin
        ReadA1   = '0;
        ReadA2   = '0;
        WriteA   = '0;
        RegWrite = 1'b0;
        memwrite = 1'b0;
        memtype  = MT_WORD;
        memsign  = 1'b0;
        memtoreg = WB_ALU;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU, FN_SUBU: begin
                        ReadA1   = rs;
                        ReadA2   = rt;
                        WriteA   = rd;
                        RegWrite = 1'b1;
                    end
                    FN_JR:   ReadA1 = rs;
                    default: ;
                endcase
            end
            OP_ORI: begin
                ReadA1   = rs;
                WriteA   = rt;
                RegWrite = 1'b1;
            end
            OP_LUI: begin
                WriteA   = rt;
                RegWrite = 1'b1;
            end
            OP_BEQ: begin
                ReadA1 = rs;
                ReadA2 = rt;
            end
            OP_J: ;
            OP_JAL: begin
                WriteA   = 5'd31;
                RegWrite = 1'b1;
            end
            OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
                ReadA1   = rs;
                WriteA   = rt;
                RegWrite = 1'b1;
                memtoreg = WB_MEM;
                memtype  = (op == OP_LW) ? MT_WORD :
                           (op == OP_LH || op == OP_LHU) ? MT_HALF : MT_BYTE;
                memsign  = (op == OP_LH || op == OP_LB);
            end
            OP_SW, OP_SH, OP_SB: begin
                ReadA1   = rs;
                ReadA2   = rt;
                memwrite = 1'b1;
                memtype  = (op == OP_SW) ? MT_WORD :
                           (op == OP_SH) ? MT_HALF : MT_BYTE;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (Trans_MemRD_Sel)
            FW_RT:   store_data = GRFRData2;
            FW_WB:   store_data = W_GRFWData;
            default: store_data = '0;
        endcase
    end

    mem_stage_dm #(
        .DM_WORDS(DM_WORDS),
        .DM_AW   (DM_AW)
    ) u_dm (
        .clk  (clk),
        .reset(reset),
        .we   (memwrite),
        .mtype(memtype),
        .msign(memsign),
        .pc   (PC),
        .addr (MemAddr),
        .wdata(store_data),
        .rdata(load_data)
    );

    assign GRFWData = (memtoreg == WB_MEM) ? load_data : EResult;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: mnemonic-level reference model with a scoreboard
// queue drained by an independent negedge monitor.
module tb_mem_stage;

    localparam int DM_WORDS = 1024;
    localparam int DM_AW    = 10;

    localparam int M_NOP = 0,  M_ADDU = 1,  M_SUBU = 2,  M_JR  = 3,  M_ORI = 4;
    localparam int M_LUI = 5,  M_BEQ  = 6,  M_J    = 7,  M_JAL = 8,  M_LW  = 9;
    localparam int M_LH  = 10, M_LHU  = 11, M_LB   = 12, M_LBU = 13, M_SW  = 14;
    localparam int M_SH  = 15, M_SB   = 16, M_UNK  = 17;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Instr = '0, PC = '0, MemAddr = '0, GRFRData2 = '0;
    logic [31:0] W_GRFWData = '0, EResult = '0;
    logic [1:0]  Trans_MemRD_Sel = '0;
    logic [31:0] GRFWData;
    logic [4:0]  ReadA1, ReadA2, WriteA;
    logic        RegWrite;

    mem_stage #(.DM_WORDS(DM_WORDS), .DM_AW(DM_AW)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .PC(PC), .MemAddr(MemAddr),
        .GRFRData2(GRFRData2), .W_GRFWData(W_GRFWData), .EResult(EResult),
        .Trans_MemRD_Sel(Trans_MemRD_Sel), .GRFWData(GRFWData),
        .ReadA1(ReadA1), .ReadA2(ReadA2), .WriteA(WriteA), .RegWrite(RegWrite)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] gw;
        logic [4:0]  a1, a2, wa;
        logic        rw;
        string       nm;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl [int];
    int          cur_m;
    logic [4:0]  cur_rs, cur_rt, cur_rd;

    function automatic bit is_load(input int m);
        return m inside {M_LW, M_LH, M_LHU, M_LB, M_LBU};
    endfunction

    function automatic bit is_store(input int m);
        return m inside {M_SW, M_SH, M_SB};
    endfunction

    function automatic logic [31:0] enc(input int m, input logic [4:0] rs, rt, rd,
                                        input logic [15:0] imm);
        case (m)
            M_ADDU: return {6'h00, rs, rt, rd, 5'd0, 6'h21};
            M_SUBU: return {6'h00, rs, rt, rd, 5'd0, 6'h23};
            M_JR:   return {6'h00, rs, 15'd0, 6'h08};
            M_ORI:  return {6'h0D, rs, rt, imm};
            M_LUI:  return {6'h0F, rs, rt, imm};
            M_BEQ:  return {6'h04, rs, rt, imm};
            M_J:    return {6'h02, rs, rt, imm};
            M_JAL:  return {6'h03, rs, rt, imm};
            M_LW:   return {6'h23, rs, rt, imm};
            M_LH:   return {6'h21, rs, rt, imm};
            M_LHU:  return {6'h25, rs, rt, imm};
            M_LB:   return {6'h20, rs, rt, imm};
            M_LBU:  return {6'h24, rs, rt, imm};
            M_SW:   return {6'h2B, rs, rt, imm};
            M_SH:   return {6'h29, rs, rt, imm};
            M_SB:   return {6'h28, rs, rt, imm};
            M_UNK:  return imm[0] ? {6'h3F, rs, rt, imm} : {6'h00, rs, rt, rd, 5'd0, 6'h2A};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] mdl_rd(input int idx);
        return mdl.exists(idx) ? mdl[idx] : 32'd0;
    endfunction

    function automatic int word_idx(input logic [31:0] a);
        return int'(a[31:2]) % DM_WORDS;
    endfunction

    function automatic exp_t predict(input string nm);
        exp_t e;
        logic [31:0] w, v;
        int sh;
        e.nm = nm;
        e.a1 = (cur_m inside {M_ADDU, M_SUBU, M_JR, M_ORI, M_BEQ} || is_load(cur_m) ||
                is_store(cur_m)) ? cur_rs : 5'd0;
        e.a2 = (cur_m inside {M_ADDU, M_SUBU, M_BEQ} || is_store(cur_m)) ? cur_rt : 5'd0;
        e.wa = (cur_m inside {M_ADDU, M_SUBU}) ? cur_rd :
               (cur_m inside {M_ORI, M_LUI} || is_load(cur_m)) ? cur_rt :
               (cur_m == M_JAL) ? 5'd31 : 5'd0;
        e.rw = (cur_m inside {M_ADDU, M_SUBU, M_ORI, M_LUI, M_JAL}) || is_load(cur_m);
        e.gw = EResult;
        if (is_load(cur_m)) begin
            w = mdl_rd(word_idx(MemAddr));
            v = w;
            if (cur_m == M_LH || cur_m == M_LHU) begin
                sh = 16 * int'(MemAddr[1]);
                v = (w >> sh) & 32'h0000FFFF;
                if (cur_m == M_LH && v[15]) v = v | 32'hFFFF0000;
            end else if (cur_m == M_LB || cur_m == M_LBU) begin
                sh = 8 * int'(MemAddr[1:0]);
                v = (w >> sh) & 32'h000000FF;
                if (cur_m == M_LB && v[7]) v = v | 32'hFFFFFF00;
            end
            e.gw = v;
        end
        return e;
    endfunction

    task automatic commit();
        logic [31:0] w, d, mask;
        int idx, sh;
        if (is_store(cur_m) && reset) begin
            d = (Trans_MemRD_Sel == 2'd0) ? GRFRData2 :
                (Trans_MemRD_Sel == 2'd1) ? W_GRFWData : 32'd0;
            idx = word_idx(MemAddr);
            w = mdl_rd(idx);
            if (cur_m == M_SW) begin
                w = d;
            end else if (cur_m == M_SH) begin
                sh = 16 * int'(MemAddr[1]);
                mask = 32'h0000FFFF << sh;
                w = (w & ~mask) | ((d & 32'h0000FFFF) << sh);
            end else begin
                sh = 8 * int'(MemAddr[1:0]);
                mask = 32'h000000FF << sh;
                w = (w & ~mask) | ((d & 32'h000000FF) << sh);
            end
            mdl[idx] = w;
        end
    endtask

    task automatic apply(input string nm, input int m, input logic [4:0] rs, rt, rd,
                         input logic [31:0] addr, rtv, wbv, er, input logic [1:0] sel);
        cur_m = m; cur_rs = rs; cur_rt = rt; cur_rd = rd;
        Instr = (m == M_NOP) ? 32'd0 : enc(m, rs, rt, rd, addr[15:0]);
        PC = PC + 32'd4;
        MemAddr = addr; GRFRData2 = rtv; W_GRFWData = wbv; EResult = er;
        Trans_MemRD_Sel = sel;
        sbq.push_back(predict(nm));
        commit();
    endtask

    task automatic step(input string nm, input int m, input logic [4:0] rs, rt, rd,
                        input logic [31:0] addr, rtv, wbv, er, input logic [1:0] sel);
        @(posedge clk);
        #1;
        apply(nm, m, rs, rt, rd, addr, rtv, wbv, er, sel);
    endtask

    // Monitor: the stage is combinational, so every cycle with a pending
    // expectation presents a response at the falling edge.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            checks++;
            if ({GRFWData, ReadA1, ReadA2, WriteA, RegWrite} !== {e.gw, e.a1, e.a2, e.wa, e.rw}) begin
                errors++;
                $display("FAIL %s: got gw=%h a1=%0d a2=%0d wa=%0d rw=%0b, need gw=%h a1=%0d a2=%0d wa=%0d rw=%0b",
                         e.nm, GRFWData, ReadA1, ReadA2, WriteA, RegWrite,
                         e.gw, e.a1, e.a2, e.wa, e.rw);
            end
        end
    end

    initial begin
        cur_m = M_NOP; cur_rs = '0; cur_rt = '0; cur_rd = '0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        apply("reset_lw", M_LW, 5'd4, 5'd7, 5'd0, 32'h10, 32'h0, 32'h0, 32'hDEAD, 2'd0);

        step("sw_20", M_SW, 5'd1, 5'd2, 5'd0, 32'h20, 32'h12345678, 32'h0, 32'h20, 2'd0);
        step("lw_20", M_LW, 5'd1, 5'd5, 5'd0, 32'h20, 32'h0, 32'h0, 32'h20, 2'd0);
        step("sb_21", M_SB, 5'd1, 5'd2, 5'd0, 32'h21, 32'h55555555, 32'hCAFE00AB, 32'h21, 2'd1);
        step("lw_merge_b", M_LW, 5'd1, 5'd6, 5'd0, 32'h20, 32'h0, 32'h0, 32'h0, 2'd0);
        step("lb_21", M_LB, 5'd1, 5'd8, 5'd0, 32'h21, 32'h0, 32'h0, 32'h0, 2'd0);
        step("lbu_21", M_LBU, 5'd1, 5'd9, 5'd0, 32'h21, 32'h0, 32'h0, 32'h0, 2'd0);
        step("sh_22", M_SH, 5'd3, 5'd4, 5'd0, 32'h22, 32'hFFFF8001, 32'h0, 32'h22, 2'd0);
        step("lh_22", M_LH, 5'd3, 5'd10, 5'd0, 32'h22, 32'h0, 32'h0, 32'h0, 2'd0);
        step("lhu_22", M_LHU, 5'd3, 5'd11, 5'd0, 32'h22, 32'h0, 32'h0, 32'h0, 2'd0);
        step("lw_merge_h", M_LW, 5'd3, 5'd12, 5'd0, 32'h20, 32'h0, 32'h0, 32'h0, 2'd0);
        step("addu", M_ADDU, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0, 32'h0, 32'h00C0FFEE, 2'd0);
        step("jal", M_JAL, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h00003008, 2'd0);
        step("beq", M_BEQ, 5'd4, 5'd5, 5'd0, 32'h0, 32'h0, 32'h0, 32'h1, 2'd0);
        step("nop", M_NOP, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);
        step("sw_sel_zero", M_SW, 5'd1, 5'd2, 5'd0, 32'h20, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 2'd2);
        step("lw_sel_zero", M_LW, 5'd1, 5'd2, 5'd0, 32'h20, 32'h0, 32'h0, 32'h0, 2'd0);
        step("sw_wrap", M_SW, 5'd1, 5'd2, 5'd0, 32'hABCD1040, 32'h0BADF00D, 32'h0, 32'h0, 2'd0);
        step("lw_wrap", M_LW, 5'd1, 5'd2, 5'd0, 32'h00000043, 32'h0, 32'h0, 32'h0, 2'd0);

        for (int i = 0; i < 400; i++) begin
            int m;
            logic [31:0] addr;
            m = (i % 3 == 0) ? int'($urandom_range(M_LW, M_SB)) : int'($urandom_range(M_NOP, M_UNK));
            addr = {$urandom} & 32'hFFFFF03F;
            step($sformatf("rand%0d_m%0d", i, m), m, 5'($urandom), 5'($urandom), 5'($urandom),
                 addr, $urandom, $urandom, $urandom, 2'($urandom));
        end

        step("pre_rst_sw", M_SW, 5'd1, 5'd2, 5'd0, 32'h50, 32'h77665544, 32'h0, 32'h0, 2'd0);
        @(posedge clk);
        #1;
        cur_m = M_LW; cur_rs = 5'd1; cur_rt = 5'd2; cur_rd = 5'd0;
        Instr = enc(M_LW, 5'd1, 5'd2, 5'd0, 16'h0050);
        MemAddr = 32'h50; EResult = 32'h0;
        #2 reset = 1'b0;
        mdl.delete();
        sbq.push_back(predict("async_clear"));
        step("sw_in_reset", M_SW, 5'd1, 5'd2, 5'd0, 32'h50, 32'h99999999, 32'h0, 32'h0, 2'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        apply("lw_after_rst", M_LW, 5'd1, 5'd2, 5'd0, 32'h50, 32'h0, 32'h0, 32'h0, 2'd0);
        step("lw_after_rst2", M_LW, 5'd1, 5'd3, 5'd0, 32'h22, 32'h0, 32'h0, 32'h0, 2'd0);

        repeat (3) @(posedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, need 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
